// File: rtl/lycan_globals.sv
// Project-wide widths and shared types for the USB packet path.
package lycan_globals;

  localparam int usb_packet_width     = 32;
  localparam int periph_address_width = 3;
  localparam int num_peripherals      = 2 ** periph_address_width;

  typedef enum logic {
    ARB_SCAN,
    ARB_HOLD
  } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational find-first-set over a request vector, searching upward
// from a rotating start pointer with wrap-around.
module rr_select #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] gnt_idx_o,
  output logic         gnt_vld_o
);

  // NOTE: every output of a combinational block is assigned a default
  // before any condition, otherwise synthesis infers a latch.
  always_comb begin
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    // Walk from the farthest candidate back to ptr_i so the nearest request wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[ptr_i + W'(i)]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = ptr_i + W'(i);
      end
    end
  end

endmodule

// File: rtl/periph_rx_arbiter.sv
// Round-robin drain of the per-peripheral RX FIFOs into the USB TX FIFO,
// with bounded bursts and the source index prepended to each payload.
module periph_rx_arbiter
  import lycan_globals::*;
#(
  parameter int NUM_PERIPH = num_peripherals,
  parameter int MAX_BURST  = 4
) (
  input  logic                                                        clk,
  input  logic                                                        rst,
  input  logic [NUM_PERIPH-1:0][usb_packet_width-periph_address_width-1:0] periph_rx_data,
  input  logic [NUM_PERIPH-1:0]                                       periph_rx_empty,
  output logic [NUM_PERIPH-1:0]                                       periph_rx_rden,
  output logic [usb_packet_width-1:0]                                 usb_tx_data,
  output logic                                                        usb_tx_wren,
  input  logic                                                        usb_tx_full,
  output logic                                                        idle
);

  localparam int          AW        = periph_address_width;
  localparam logic [7:0]  BURST_MAX = 8'(MAX_BURST);

  arb_state_e                  state_q, state_d;
  logic [AW-1:0]               last_grant_q, last_grant_d;
  logic [7:0]                  burst_cnt_q, burst_cnt_d;
  logic [usb_packet_width-1:0] out_word_q;
  logic                        out_valid_q;

  logic          load_ok;
  logic          pop;
  logic [AW-1:0] pop_idx;
  logic [AW-1:0] scan_ptr;
  logic [AW-1:0] gnt_idx;
  logic          gnt_vld;
  logic [NUM_PERIPH-1:0] req;

  // Reset gates the strobes so a reset cycle neither drops a FIFO word nor
  // writes the word being discarded.
  assign usb_tx_wren = out_valid_q & ~usb_tx_full & ~rst;
  assign load_ok     = ~out_valid_q | usb_tx_wren;
  assign idle        = ~out_valid_q & (&periph_rx_empty);
  assign usb_tx_data = out_word_q;

  assign req      = ~periph_rx_empty;
  assign scan_ptr = last_grant_q + AW'(1);

  rr_select #(
    .N(NUM_PERIPH),
    .W(AW)
  ) u_rr_select (
    .req_i    (req),
    .ptr_i    (scan_ptr),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    pop          = 1'b0;
    pop_idx      = last_grant_q;

    if (state_q == ARB_HOLD && !periph_rx_empty[last_grant_q] && burst_cnt_q < BURST_MAX) begin
      // Owner keeps the grant; a stall simply waits here with the count frozen.
      if (load_ok) begin
        pop         = 1'b1;
        burst_cnt_d = burst_cnt_q + 8'd1;
      end
    end else begin
      // Scan in the same cycle the burst ends so rotation costs no bubble.
      state_d = ARB_SCAN;
      if (gnt_vld && load_ok) begin
        pop          = 1'b1;
        pop_idx      = gnt_idx;
        last_grant_d = gnt_idx;
        burst_cnt_d  = 8'd1;
        state_d      = (MAX_BURST > 1) ? ARB_HOLD : ARB_SCAN;
      end
    end

    if (rst) begin
      pop = 1'b0;
    end
  end

  assign periph_rx_rden = pop ? (NUM_PERIPH'(1) << pop_idx) : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_SCAN;
      last_grant_q <= AW'(NUM_PERIPH - 1);
      burst_cnt_q  <= '0;
      out_word_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      if (pop) begin
        out_word_q  <= {pop_idx, periph_rx_data[pop_idx]};
        out_valid_q <= 1'b1;
      end else if (usb_tx_wren) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule
